irq_sequencer: RTL and testbench
================================

Name: irq_sequencer

Overview:
Sequences external and software interrupts into the MIPS core: edge-captures four IRQ lines plus the software trap, masks and prioritises them, and requests an exception from the pipeline with a handshake. It saves the victim PC (EPC), tracks the in-service state until ERET, then issues the return redirect. It sits between the interrupt sources, the Cause/Status logic and the fetch/control unit.

Parameters:
DATA_WIDTH, 32, width of PC, EPC and Cause image; minimum 16.
VECTOR_ADDR, 32'h0000_0180, handler entry address driven on o_vector.

Ports:
i_clk  in  1  clock; all state updates on rising edge.
i_nrst  in  1  reset, synchronous, active-low.
i_irq  in  4  level hardware interrupt lines, already synchronous to i_clk.
i_trig  in  1  software trap strobe, one cycle.
i_ie  in  1  global interrupt enable from Status.
i_mask  in  4  per-line enable from Status (bit n enables i_irq[n]).
i_pc  in  DATA_WIDTH  PC of the instruction to be interrupted.
i_stall  in  1  pipeline stalled; dispatch is blocked.
i_exc_ack  in  1  pipeline has taken the exception.
i_eret  in  1  ERET executing, one cycle.
i_we  in  1  Cause write strobe; write-1-to-clear pending.
i_data  in  DATA_WIDTH  write data for i_we.
o_exc_req  out  1  exception request to control unit.
o_flush  out  1  one-cycle pipeline flush pulse at dispatch.
o_vector  out  DATA_WIDTH  handler address; VECTOR_ADDR while o_exc_req is high, else 0.
o_epc  out  DATA_WIDTH  saved PC.
o_redirect  out  1  one-cycle return pulse; fetch loads o_epc.
o_in_service  out  1  handler running; nesting is blocked.
o_cause  out  DATA_WIDTH  Cause image.

Behaviour:
- Reset (i_nrst low at a clock edge): state IDLE; pending = 0; EPC = 0; winner = 0; prev_irq = 0. All outputs are 0.
- Capture:
  - pend_hw[n] is set on a rising edge of i_irq[n] (i_irq & ~prev_irq).
  - pend_sw is set by i_trig.
  - A set in the same cycle as a clear (dispatch clear or write-1-clear) of the same bit leaves the bit set.
- Write-1-to-clear: i_we with i_data[11:8] clears matching pend_hw bits; i_data[15] clears pend_sw. All other bits are ignored.
- Eligible set: pend_sw, or (pend_hw & i_mask), gated by i_ie. Fixed priority, highest first: sw, irq3, irq2, irq1, irq0. Winner code: sw=4, irqn=n.
- FSM:
  - IDLE: if an eligible source exists and !i_stall, then latch winner, EPC<=i_pc, clear the winner's pending bit, pulse o_flush, go to REQ. Otherwise stay in IDLE.
  - REQ: o_exc_req=1 and o_vector valid. On i_exc_ack, go to SERVICE. i_stall and i_ie are ignored in this state; a request is never withdrawn.
  - SERVICE: o_in_service=1. New edges keep accumulating as pending, but no dispatch occurs. On i_eret, go to RET.
  - RET: pulse o_redirect for one cycle, go to IDLE. Dispatch is possible on the following cycle at the earliest.
- i_eret outside SERVICE is ignored. i_exc_ack outside REQ is ignored.
- Latency: edge at cycle t is pending at t+1. The dispatch decision and o_flush occur at t+1, and o_exc_req is high from t+2.
- o_cause:
  - [15] = pend_sw.
  - [11:8] = pend_hw, unmasked.
  - [6:4] = winner code of the last dispatch.
  - [0] = o_in_service.
  - All other bits are 0.
- Reset asserted in any state returns everything to reset values at that edge. No pending requests survive reset.

Test Plan:
- Reset mid-SERVICE with pend_hw=4'b0101 -> next cycle state IDLE, o_cause=0, o_epc=0, no o_redirect.
- i_ie=1, i_mask=4'hF, i_pc=32'h0000_0040, pulse i_irq[1] -> o_flush at t+1, o_exc_req from t+2. Ack -> o_in_service=1, o_epc=32'h40, o_cause[6:4]=1. i_eret -> o_redirect single pulse, then IDLE.
- Simultaneous i_trig and rising i_irq[3] and i_irq[0] -> sw dispatched first (code 4). After ERET+RET, irq3 is dispatched, then irq0. Three complete sequences in total.
- i_mask=4'b1110, i_irq[0] edge -> no request, o_cause[8]=1. Write i_data[8]=1 -> o_cause[8]=0. Write in the same cycle as a new edge -> bit stays 1.
- i_stall held 5 cycles with eligible irq2 -> no o_flush during the stall; dispatch occurs on the first unstalled cycle with EPC = i_pc of that cycle. i_irq[2] held high produces only one pending (edge-triggered).
- Edge on irq1 during SERVICE -> pending shows in o_cause[9], but no o_exc_req until after o_redirect. i_ie=0 in IDLE -> no dispatch.

Source files
------------

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: edge-captures four IRQ lines and the software trap,
// prioritises them, hands one exception at a time to the pipeline and returns via ERET.
module irq_sequencer #(
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] VECTOR_ADDR = DATA_WIDTH'(32'h0000_0180)
) (
   input  logic                  i_clk,
   input  logic                  i_nrst,
   input  logic [3:0]            i_irq,
   input  logic                  i_trig,
   input  logic                  i_ie,
   input  logic [3:0]            i_mask,
   input  logic [DATA_WIDTH-1:0] i_pc,
   input  logic                  i_stall,
   input  logic                  i_exc_ack,
   input  logic                  i_eret,
   input  logic                  i_we,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_exc_req,
   output logic                  o_flush,
   output logic [DATA_WIDTH-1:0] o_vector,
   output logic [DATA_WIDTH-1:0] o_epc,
   output logic                  o_redirect,
   output logic                  o_in_service,
   output logic [DATA_WIDTH-1:0] o_cause
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE, RET} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [3:0]              pend_hw;
   logic                    pend_sw;
   logic [3:0]              prev_irq;
   logic [DATA_WIDTH-1:0]   epc;
   logic [2:0]              winner;

   logic [3:0]              elig_hw;
   logic                    elig_sw;
   logic                    any_elig;
   logic [2:0]              pick;
   logic                    dispatch;
   logic [3:0]              clr_hw;
   logic                    clr_sw;
   logic [3:0]              rise;

   assign elig_hw  = pend_hw & i_mask & {4{i_ie}};
   assign elig_sw  = pend_sw & i_ie;
   assign any_elig = elig_sw | (|elig_hw);
   assign dispatch = (state == IDLE) && any_elig && !i_stall;
   assign rise     = i_irq & ~prev_irq;

   // Fixed priority: software trap first, then irq3 down to irq0.
   always_comb begin
      pick = 3'd0;
      if (elig_sw)         pick = 3'd4;
      else if (elig_hw[3]) pick = 3'd3;
      else if (elig_hw[2]) pick = 3'd2;
      else if (elig_hw[1]) pick = 3'd1;
      else                 pick = 3'd0;
   end

   always_comb begin
      clr_hw = i_we ? i_data[11:8] : 4'b0000;
      clr_sw = i_we & i_data[15];
      if (dispatch) begin
         if (pick == 3'd4) clr_sw = 1'b1;
         else              clr_hw = clr_hw | (4'b0001 << pick[1:0]);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (dispatch)  state_nxt = REQ;
         REQ:     if (i_exc_ack) state_nxt = SERVICE;
         SERVICE: if (i_eret)    state_nxt = RET;
         RET:                    state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // A new edge wins over a clear of the same bit in the same cycle.
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         state    <= IDLE;
         pend_hw  <= '0;
         pend_sw  <= 1'b0;
         prev_irq <= '0;
         epc      <= '0;
         winner   <= '0;
      end else begin
         state    <= state_nxt;
         pend_hw  <= (pend_hw & ~clr_hw) | rise;
         pend_sw  <= (pend_sw & ~clr_sw) | i_trig;
         prev_irq <= i_irq;
         if (dispatch) begin
            epc    <= i_pc;
            winner <= pick;
         end
      end
   end

   assign o_exc_req    = (state == REQ);
   assign o_flush      = dispatch;
   assign o_vector     = (state == REQ) ? VECTOR_ADDR : '0;
   assign o_epc        = epc;
   assign o_redirect   = (state == RET);
   assign o_in_service = (state == SERVICE);

   always_comb begin
      o_cause       = '0;
      o_cause[15]   = pend_sw;
      o_cause[11:8] = pend_hw;
      o_cause[6:4]  = winner;
      o_cause[0]    = (state == SERVICE);
   end

   logic unused_data;
   assign unused_data = ^{i_data[DATA_WIDTH-1:16], i_data[14:12], i_data[7:0]};

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: directed scenarios plus a randomized run against a
// source-indexed reference model (index 4 = software trap, highest index wins).
module tb_irq_sequencer;
   localparam int             DW  = 32;
   localparam logic [DW-1:0]  VEC = 32'h0000_0180;
   localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2, M_RET = 3;

   logic           clk = 1'b0;
   logic           nrst = 1'b0;
   logic [3:0]     irq = '0;
   logic           trig = 1'b0;
   logic           ie = 1'b0;
   logic [3:0]     mask = '0;
   logic [DW-1:0]  pc = '0;
   logic           stall = 1'b0;
   logic           exc_ack = 1'b0;
   logic           eret = 1'b0;
   logic           we = 1'b0;
   logic [DW-1:0]  data = '0;
   logic           exc_req, flush, redirect, in_service;
   logic [DW-1:0]  vector, epc, cause;

   int n_cmp = 0;
   int n_err = 0;
   logic [DW+2:0] exp_q[$];

   int            m_mode = M_IDLE;
   logic [4:0]    m_pend = '0;
   logic [3:0]    m_prev = '0;
   logic [DW-1:0] m_epc = '0;
   logic [2:0]    m_code = '0;

   irq_sequencer #(.DATA_WIDTH(DW), .VECTOR_ADDR(VEC)) dut (
      .i_clk(clk), .i_nrst(nrst), .i_irq(irq), .i_trig(trig), .i_ie(ie),
      .i_mask(mask), .i_pc(pc), .i_stall(stall), .i_exc_ack(exc_ack),
      .i_eret(eret), .i_we(we), .i_data(data),
      .o_exc_req(exc_req), .o_flush(flush), .o_vector(vector), .o_epc(epc),
      .o_redirect(redirect), .o_in_service(in_service), .o_cause(cause)
   );

   always #5 clk = ~clk;

   function automatic int m_best();
      m_best = -1;
      for (int i = 0; i <= 4; i++)
         if (m_pend[i] && ie && (i == 4 || mask[i[1:0]])) m_best = i;
   endfunction

   function automatic logic m_flush();
      return (m_mode == M_IDLE) && !stall && (m_best() >= 0);
   endfunction

   function automatic logic [DW-1:0] m_cause();
      logic [DW-1:0] c;
      c = '0;
      c[15]   = m_pend[4];
      c[11:8] = m_pend[3:0];
      c[6:4]  = m_code;
      c[0]    = (m_mode == M_SVC);
      return c;
   endfunction

   always @(posedge clk) begin : ref_model
      int   b;
      logic disp;
      if (!nrst) begin
         m_mode <= M_IDLE; m_pend <= '0; m_prev <= '0; m_epc <= '0; m_code <= '0;
         exp_q.delete();
      end else begin
         b    = m_best();
         disp = (m_mode == M_IDLE) && !stall && (b >= 0);
         for (int i = 0; i < 4; i++)
            m_pend[i] <= (irq[i] && !m_prev[i]) || (m_pend[i] && !((disp && b == i) || (we && data[8+i])));
         m_pend[4] <= trig || (m_pend[4] && !((disp && b == 4) || (we && data[15])));
         m_prev <= irq;
         if (disp) begin
            m_epc <= pc; m_code <= 3'(b); m_mode <= M_REQ;
            exp_q.push_back({3'(b), pc});
         end else if (m_mode == M_REQ && exc_ack) m_mode <= M_SVC;
         else if (m_mode == M_SVC && eret)        m_mode <= M_RET;
         else if (m_mode == M_RET)                m_mode <= M_IDLE;
      end
   end

   task automatic advance(); @(posedge clk); #1; endtask
   task automatic settle();  @(negedge clk);     endtask

   task automatic test_reset();
      nrst = 1'b0; irq = '0; ie = 1'b0; mask = '0; pc = '0;
      trig = 0; exc_ack = 0; eret = 0; we = 0; data = '0; stall = 0;
      advance(); advance(); settle();
      n_cmp++; if ({exc_req, flush, redirect, in_service} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b exp 0000", {exc_req, flush, redirect, in_service}); end
      n_cmp++; if ({vector, epc, cause} !== '0) begin n_err++; $display("FAIL reset_words: got %h/%h/%h exp 0", vector, epc, cause); end
      nrst = 1'b1;
      advance();
   endtask

   task automatic test_single_irq();
      ie = 1; mask = 4'hF; pc = 32'h0000_0040; irq = '0;
      advance();
      irq[1] = 1'b1;
      settle();
      n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL single_flush_t: got %b exp 0", flush); end
      advance(); irq[1] = 1'b0; settle();
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL single_flush_t1: got %b exp 1", flush); end
      n_cmp++; if (exc_req !== 1'b0) begin n_err++; $display("FAIL single_req_t1: got %b exp 0", exc_req); end
      advance(); exc_ack = 1'b1; settle();
      n_cmp++; if (exc_req !== 1'b1) begin n_err++; $display("FAIL single_req_t2: got %b exp 1", exc_req); end
      n_cmp++; if (vector !== VEC) begin n_err++; $display("FAIL single_vector: got %h exp %h", vector, VEC); end
      advance(); exc_ack = 1'b0; settle();
      n_cmp++; if (in_service !== 1'b1) begin n_err++; $display("FAIL single_in_service: got %b exp 1", in_service); end
      n_cmp++; if (epc !== 32'h40) begin n_err++; $display("FAIL single_epc: got %h exp 40", epc); end
      n_cmp++; if (cause[6:4] !== 3'd1) begin n_err++; $display("FAIL single_code: got %0d exp 1", cause[6:4]); end
      n_cmp++; if (vector !== '0) begin n_err++; $display("FAIL single_vector_svc: got %h exp 0", vector); end
      eret = 1'b1; advance(); eret = 1'b0; settle();
      n_cmp++; if ({redirect, in_service} !== 2'b10) begin n_err++; $display("FAIL single_redirect: got %b exp 10", {redirect, in_service}); end
      advance(); settle();
      n_cmp++; if ({redirect, exc_req, flush} !== 3'b000) begin n_err++; $display("FAIL single_idle: got %b exp 000", {redirect, exc_req, flush}); end
   endtask

   task automatic test_priority();
      logic [2:0] codes [3];
      logic found;
      codes[0] = 3'd4; codes[1] = 3'd3; codes[2] = 3'd0;
      ie = 1; mask = 4'hF; irq = '0;
      advance();
      trig = 1'b1; irq = 4'b1001; pc = 32'h0000_0100;
      advance(); trig = 1'b0;
      for (int k = 0; k < 3; k++) begin
         found = 1'b0;
         for (int c = 0; c < 8; c++) begin
            settle();
            if (flush === 1'b1) begin found = 1'b1; break; end
            advance();
         end
         n_cmp++; if (!found) begin n_err++; $display("FAIL prio_dispatch_%0d: got no flush exp flush", k); end
         if (found) begin
            advance(); exc_ack = 1'b1; settle();
            n_cmp++; if (exc_req !== 1'b1) begin n_err++; $display("FAIL prio_req_%0d: got %b exp 1", k, exc_req); end
            advance(); exc_ack = 1'b0; settle();
            n_cmp++; if (cause[6:4] !== codes[k]) begin n_err++; $display("FAIL prio_code_%0d: got %0d exp %0d", k, cause[6:4], codes[k]); end
            eret = 1'b1; advance(); eret = 1'b0; settle();
            n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL prio_redirect_%0d: got %b exp 1", k, redirect); end
            advance();
         end
      end
      settle();
      n_cmp++; if ({flush, cause[15], cause[11:8]} !== 6'b0) begin n_err++; $display("FAIL prio_drained: got %b exp 0", {flush, cause[15], cause[11:8]}); end
      irq = '0;
      advance();
   endtask

   task automatic test_mask_w1c();
      ie = 1; mask = 4'b1110; irq = '0;
      advance();
      irq[0] = 1'b1; advance(); irq[0] = 1'b0; settle();
      n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL mask_flush: got %b exp 0", flush); end
      n_cmp++; if (cause[8] !== 1'b1) begin n_err++; $display("FAIL mask_pending: got %b exp 1", cause[8]); end
      advance(); settle();
      n_cmp++; if (exc_req !== 1'b0) begin n_err++; $display("FAIL mask_req: got %b exp 0", exc_req); end
      we = 1'b1; data = ~32'h0000_8F00; advance(); we = 1'b0; settle();
      n_cmp++; if (cause[8] !== 1'b1) begin n_err++; $display("FAIL w1c_ignored_bits: got %b exp 1", cause[8]); end
      we = 1'b1; data = 32'h0000_0100; advance(); we = 1'b0; settle();
      n_cmp++; if (cause[8] !== 1'b0) begin n_err++; $display("FAIL w1c_clear: got %b exp 0", cause[8]); end
      irq[0] = 1'b1; advance(); irq[0] = 1'b0; advance();
      irq[0] = 1'b1; we = 1'b1; data = 32'h0000_0100; advance();
      irq[0] = 1'b0; we = 1'b0; settle();
      n_cmp++; if (cause[8] !== 1'b1) begin n_err++; $display("FAIL w1c_vs_edge: got %b exp 1", cause[8]); end
      we = 1'b1; advance(); we = 1'b0; mask = 4'hF;
      advance();
   endtask

   task automatic test_stall();
      ie = 1; mask = 4'hF; irq = '0;
      advance();
      stall = 1'b1; irq[2] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pc = $urandom; settle();
         n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL stall_flush_%0d: got %b exp 0", i, flush); end
         advance();
      end
      stall = 1'b0; pc = 32'h0000_1234; settle();
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL stall_release: got %b exp 1", flush); end
      advance(); stall = 1'b1; ie = 1'b0; settle();
      n_cmp++; if (epc !== 32'h1234) begin n_err++; $display("FAIL stall_epc: got %h exp 1234", epc); end
      advance(); settle();
      n_cmp++; if ({exc_req, vector} !== {1'b1, VEC}) begin n_err++; $display("FAIL req_held: got %b/%h exp 1/%h", exc_req, vector, VEC); end
      exc_ack = 1'b1; stall = 1'b0; ie = 1'b1;
      advance(); exc_ack = 1'b0; eret = 1'b1; advance(); eret = 1'b0; settle();
      n_cmp++; if (redirect !== 1'b1) begin n_err++; $display("FAIL stall_redirect: got %b exp 1", redirect); end
      advance();
      for (int i = 0; i < 3; i++) begin
         settle();
         n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL level_single_%0d: got %b exp 0", i, flush); end
         advance();
      end
      irq = '0;
      advance();
   endtask

   task automatic test_nested();
      ie = 1; mask = 4'hF; irq = '0;
      advance();
      irq[0] = 1'b1; advance(); irq[0] = 1'b0; settle();
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL nest_first: got %b exp 1", flush); end
      advance(); exc_ack = 1'b1; advance(); exc_ack = 1'b0;
      irq[1] = 1'b1; advance(); irq[1] = 1'b0; settle();
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if ({in_service, cause[9], exc_req, flush} !== 4'b1100) begin n_err++; $display("FAIL nest_blocked_%0d: got %b exp 1100", i, {in_service, cause[9], exc_req, flush}); end
         advance(); settle();
      end
      eret = 1'b1; advance(); eret = 1'b0; settle();
      n_cmp++; if ({redirect, flush, exc_req} !== 3'b100) begin n_err++; $display("FAIL nest_ret: got %b exp 100", {redirect, flush, exc_req}); end
      advance(); settle();
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL nest_after_ret: got %b exp 1", flush); end
      advance(); settle();
      n_cmp++; if ({exc_req, cause[6:4]} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL nest_second: got %b/%0d exp 1/1", exc_req, cause[6:4]); end
      exc_ack = 1'b1; advance(); exc_ack = 1'b0; eret = 1'b1; advance(); eret = 1'b0; advance();
      ie = 1'b0;
      irq[3] = 1'b1; advance(); irq[3] = 1'b0; settle();
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if ({flush, cause[11]} !== 2'b01) begin n_err++; $display("FAIL ie_off_%0d: got %b exp 01", i, {flush, cause[11]}); end
         advance(); settle();
      end
      we = 1'b1; data = 32'h0000_0800; advance(); we = 1'b0; ie = 1'b1; settle();
      n_cmp++; if ({flush, cause[11]} !== 2'b00) begin n_err++; $display("FAIL ie_off_clear: got %b exp 00", {flush, cause[11]}); end
      advance();
   endtask

   task automatic test_reset_mid_service();
      ie = 1; mask = 4'hF; irq = '0;
      advance();
      irq[3] = 1'b1; advance(); irq[3] = 1'b0; advance();
      exc_ack = 1'b1; advance(); exc_ack = 1'b0;
      irq = 4'b0101; advance(); irq = '0; settle();
      n_cmp++; if ({in_service, cause[11:8]} !== 5'b10101) begin n_err++; $display("FAIL rst_svc_setup: got %b exp 10101", {in_service, cause[11:8]}); end
      nrst = 1'b0; advance(); nrst = 1'b1; settle();
      n_cmp++; if ({exc_req, flush, redirect, in_service} !== 4'b0) begin n_err++; $display("FAIL rst_svc_flags: got %b exp 0000", {exc_req, flush, redirect, in_service}); end
      n_cmp++; if ({cause, epc} !== '0) begin n_err++; $display("FAIL rst_svc_words: got %h/%h exp 0", cause, epc); end
      advance(); settle();
      n_cmp++; if ({flush, cause} !== '0) begin n_err++; $display("FAIL rst_svc_no_pending: got %b/%h exp 0", flush, cause); end
      advance();
   endtask

   task automatic test_random();
      logic          was_svc;
      logic [DW+2:0] e;
      exp_q.delete();
      was_svc = in_service;
      for (int n = 0; n < 600; n++) begin
         nrst    = ($urandom_range(99) != 0);
         if ($urandom_range(3) == 0) irq = irq ^ 4'($urandom_range(15));
         trig    = ($urandom_range(9) == 0);
         ie      = ($urandom_range(9) != 0);
         if ($urandom_range(19) == 0) mask = 4'($urandom_range(15));
         pc      = $urandom;
         stall   = ($urandom_range(3) == 0);
         exc_ack = 1'($urandom_range(1));
         eret    = ($urandom_range(2) == 0);
         we      = ($urandom_range(9) == 0);
         data    = $urandom;
         settle();
         n_cmp++; if (exc_req !== (m_mode == M_REQ)) begin n_err++; $display("FAIL rnd_exc_req@%0d: got %b exp %b", n, exc_req, m_mode == M_REQ); end
         n_cmp++; if (flush !== m_flush()) begin n_err++; $display("FAIL rnd_flush@%0d: got %b exp %b", n, flush, m_flush()); end
         n_cmp++; if (vector !== ((m_mode == M_REQ) ? VEC : '0)) begin n_err++; $display("FAIL rnd_vector@%0d: got %h", n, vector); end
         n_cmp++; if (epc !== m_epc) begin n_err++; $display("FAIL rnd_epc@%0d: got %h exp %h", n, epc, m_epc); end
         n_cmp++; if (redirect !== (m_mode == M_RET)) begin n_err++; $display("FAIL rnd_redirect@%0d: got %b exp %b", n, redirect, m_mode == M_RET); end
         n_cmp++; if (in_service !== (m_mode == M_SVC)) begin n_err++; $display("FAIL rnd_in_service@%0d: got %b exp %b", n, in_service, m_mode == M_SVC); end
         n_cmp++; if (cause !== m_cause()) begin n_err++; $display("FAIL rnd_cause@%0d: got %h exp %h", n, cause, m_cause()); end
         if (in_service === 1'b1 && !was_svc) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++; $display("FAIL sb_empty@%0d: got service entry exp none", n);
            end else begin
               e = exp_q.pop_front();
               if ({cause[6:4], epc} !== e) begin n_err++; $display("FAIL sb_dispatch@%0d: got %h exp %h", n, {cause[6:4], epc}, e); end
            end
         end
         was_svc = (in_service === 1'b1);
         advance();
      end
      nrst = 1'b1; trig = 0; exc_ack = 0; eret = 0; we = 0; stall = 0; irq = '0;
      advance();
   endtask

   initial begin
      test_reset();
      test_single_irq();
      test_priority();
      test_mask_w1c();
      test_stall();
      test_nested();
      test_reset_mid_service();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "bench timed out");
   end

endmodule
